klein_sbox_layer_serial: RTL and testbench

Nibble-serial KLEIN substitution layer for the decryption datapath. It accepts one 64-bit state word per transaction over a valid/ready handshake and applies the 4-bit KLEIN S-box to all 16 nibbles. Nibbles are processed in groups of NPAR per cycle through NPAR copies of the team's combinational 4-bit S-box cell. The block sits between the AddRoundKey/inverse-MixNibbles stages and the next round register, and trades area against latency.

---
 rtl/klein_sbox_layer_serial.sv | 125 ++++++++++++
 tb/tb_klein_sbox_layer_serial.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/klein_sbox_layer_serial.sv
// Nibble-serial KLEIN S-box layer: substitutes NPAR nibbles per cycle and rotates the state.
// Optional macro KLEIN_SLAYER_BACK2BACK_EN lets DONE hand off directly to a new word.
module klein_sbox_layer_serial #(
    parameter int NPAR = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
);
    // state | meaning
    // IDLE  | waiting for a word, in_ready high
    // RUN   | substituting NPAR nibbles per cycle while rotating
    // DONE  | result held on out_data until out_ready
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int         W    = 4 * NPAR;
    localparam int         N    = 16 / NPAR;
    localparam logic [3:0] LAST = 4'(N - 1);

    if (!(NPAR == 1 || NPAR == 2 || NPAR == 4 || NPAR == 8 || NPAR == 16)) begin : g_bad_npar
        $error("klein_sbox_layer_serial: NPAR must be 1, 2, 4, 8 or 16");
    end

    logic [1:0]  fsm;
    logic [3:0]  cnt;
    logic [63:0] state;
    logic [63:0] sub_state;
    logic [63:0] rot_state;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h7;
            4'h1: y = 4'h4;
            4'h2: y = 4'hA;
            4'h3: y = 4'h9;
            4'h4: y = 4'h1;
            4'h5: y = 4'hF;
            4'h6: y = 4'hB;
            4'h7: y = 4'h0;
            4'h8: y = 4'hC;
            4'h9: y = 4'h3;
            4'hA: y = 4'h2;
            4'hB: y = 4'h6;
            4'hC: y = 4'h8;
            4'hD: y = 4'hE;
            4'hE: y = 4'hD;
            default: y = 4'h5;
        endcase
        return y;
    endfunction

    always_comb begin
        sub_state = state;
        for (int i = 0; i < NPAR; i++) begin
            sub_state[4*i +: 4] = sbox(state[4*i +: 4]);
        end
    end

    // Substituted nibbles move to the top; after N steps the original order returns.
    if (NPAR == 16) begin : g_rot_full
        assign rot_state = sub_state;
    end else begin : g_rot_part
        assign rot_state = {sub_state[W-1:0], sub_state[63:W]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm   <= IDLE;
            cnt   <= 4'd0;
            state <= 64'd0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        state <= in_data;
                        cnt   <= 4'd0;
                        fsm   <= RUN;
                    end
                end
                RUN: begin
                    state <= rot_state;
                    cnt   <= cnt + 4'd1;
                    if (cnt == LAST) begin
                        fsm <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
`ifdef KLEIN_SLAYER_BACK2BACK_EN
                        if (in_valid) begin
                            state <= in_data;
                            cnt   <= 4'd0;
                            fsm   <= RUN;
                        end else begin
                            fsm <= IDLE;
                        end
`else
                        fsm <= IDLE;
`endif
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

`ifdef KLEIN_SLAYER_BACK2BACK_EN
    assign in_ready = (fsm == IDLE) || ((fsm == DONE) && out_ready);
`else
    assign in_ready = (fsm == IDLE);
`endif
    assign out_valid = (fsm == DONE);
    assign busy      = (fsm == RUN) || (fsm == DONE);
    assign out_data  = state;

endmodule

// File: tb/tb_klein_sbox_layer_serial.sv
// Bench for klein_sbox_layer_serial: NPAR=2 directed vectors and corner cases, plus NPAR=1/4/16 sweep.
module tb_klein_sbox_layer_serial;
    logic        clk;
    logic        rst_n;
    logic        iv   [4];
    logic        ir   [4];
    logic [63:0] id   [4];
    logic        ov   [4];
    logic        ordy [4];
    logic [63:0] od   [4];
    logic        bz   [4];

    int checks;
    int errors;

    typedef struct {
        logic [63:0] din;
        logic [63:0] dout;
    } vec_t;
    vec_t vt[5];

    logic [3:0] sb_tab[16];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int NP = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 16;
        klein_sbox_layer_serial #(.NPAR(NP)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .in_data   (id[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .out_data  (od[g]),
            .busy      (bz[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int np_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : (k == 2) ? 4 : 16;
    endfunction

    function automatic logic [63:0] model(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = sb_tab[x[4*i +: 4]];
        return y;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Sends one word on instance k with out_ready=1; returns result and accept-to-valid latency.
    task automatic run_word(input int k, input logic [63:0] d,
                            output logic [63:0] res, output int lat);
        int guard;
        @(negedge clk);
        id[k] = d;
        iv[k] = 1'b1;
        ordy[k] = 1'b1;
        guard = 0;
        while (!ir[k] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
        lat = 0;
        while (!ov[k] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = od[k];
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] res;
        logic [63:0] held;
        logic [63:0] wb[3];
        int lat;
        int n_in, n_out, cyc, last_cyc;
        logic fi, fo;
        logic [63:0] fdat;
        int exp_gap;

        checks = 0;
        errors = 0;
        sb_tab = '{4'h7, 4'h4, 4'hA, 4'h9, 4'h1, 4'hF, 4'hB, 4'h0,
                   4'hC, 4'h3, 4'h2, 4'h6, 4'h8, 4'hE, 4'hD, 4'h5};
        vt[0] = '{64'h0123456789ABCDEF, 64'h74A91FB0C3268ED5};
        vt[1] = '{64'h74A91FB0C3268ED5, 64'h0123456789ABCDEF};
        vt[2] = '{64'h0000000000000000, 64'h7777777777777777};
        vt[3] = '{64'hFFFFFFFFFFFFFFFF, 64'h5555555555555555};
        vt[4] = '{64'hDEADBEEF00C0FFEE, 64'hED2E6DD5778755DD};

        for (int k = 0; k < 4; k++) begin
            iv[k] = 1'b0;
            id[k] = 64'd0;
            ordy[k] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 64'(ir[0]), 64'd1);
        chk("reset out_valid", 64'(ov[0]), 64'd0);
        chk("reset busy", 64'(bz[0]), 64'd0);
        chk("reset out_data", od[0], 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            run_word(0, vt[v].din, res, lat);
            chk($sformatf("vec%0d latency", v), 64'(lat), 64'd8);
            chk($sformatf("vec%0d data", v), res, vt[v].dout);
            chk($sformatf("vec%0d idle after", v), 64'(ir[0]), 64'd1);
        end

        // Backpressure in DONE for 5 cycles.
        @(negedge clk);
        ordy[0] = 1'b0;
        id[0] = 64'h0123456789ABCDEF;
        iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        chk("bp busy in run", 64'(bz[0]), 64'd1);
        chk("bp in_ready in run", 64'(ir[0]), 64'd0);
        lat = 0;
        while (!ov[0] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp latency", 64'(lat), 64'd8);
        held = od[0];
        chk("bp data", held, 64'h74A91FB0C3268ED5);
        iv[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp hold valid c%0d", c), 64'(ov[0]), 64'd1);
            chk($sformatf("bp hold data c%0d", c), od[0], held);
            chk($sformatf("bp hold in_ready c%0d", c), 64'(ir[0]), 64'd0);
        end
        iv[0] = 1'b0;
        @(negedge clk);
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp retire valid", 64'(ov[0]), 64'd0);
        chk("bp retire in_ready", 64'(ir[0]), 64'd1);
        @(posedge clk);
        #1;
        chk("bp single transfer", 64'(ov[0]), 64'd0);

        // Reset while cnt==3 in RUN.
        @(negedge clk);
        id[0] = 64'hDEADBEEF00C0FFEE;
        iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst mid in_ready", 64'(ir[0]), 64'd1);
        chk("rst mid out_valid", 64'(ov[0]), 64'd0);
        chk("rst mid out_data", od[0], 64'd0);
        chk("rst mid busy", 64'(bz[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_word(0, 64'h0123456789ABCDEF, res, lat);
        chk("post rst latency", 64'(lat), 64'd8);
        chk("post rst data", res, 64'h74A91FB0C3268ED5);

        // Three words with in_valid and out_ready held high.
`ifdef KLEIN_SLAYER_BACK2BACK_EN
        exp_gap = 9;
`else
        exp_gap = 10;
`endif
        wb[0] = 64'h0123456789ABCDEF;
        wb[1] = 64'hDEADBEEF00C0FFEE;
        wb[2] = 64'h0000000000000000;
        n_in = 0;
        n_out = 0;
        cyc = 0;
        last_cyc = 0;
        ordy[0] = 1'b1;
        id[0] = wb[0];
        iv[0] = 1'b1;
        while (n_out < 3 && cyc < 80) begin
            @(negedge clk);
            fi = iv[0] && ir[0];
            fo = ov[0] && ordy[0];
            fdat = od[0];
            @(posedge clk);
            cyc++;
            if (fo) begin
                chk($sformatf("b2b data %0d", n_out), fdat, model(wb[n_out]));
                if (n_out > 0) chk($sformatf("b2b gap %0d", n_out), 64'(cyc - last_cyc), 64'(exp_gap));
                last_cyc = cyc;
                n_out++;
            end
            #1;
            if (fi) begin
                n_in++;
                if (n_in < 3) id[0] = wb[n_in];
                else iv[0] = 1'b0;
            end
        end
        iv[0] = 1'b0;
        chk("b2b result count", 64'(n_out), 64'd3);

        // NPAR sweep against the table model.
        for (int k = 1; k < 4; k++) begin
            for (int r = 0; r < 4; r++) begin
                logic [63:0] w;
                w = {$urandom, $urandom};
                run_word(k, w, res, lat);
                chk($sformatf("sweep np%0d latency", np_of(k)), 64'(lat), 64'(16 / np_of(k)));
                chk($sformatf("sweep np%0d data %h", np_of(k), w), res, model(w));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
